int_add_rs: RTL

Reservation station for the integer add/sub functional unit of the Tomasulo core. It accepts issued instructions with either operand values or producer tags. It snoops the common data bus (CDB) to capture pending operands. It dispatches operand-complete entries to the 32-bit carry-lookahead adder through a registered valid/ready port. It sits directly upstream of the adder, which consumes ex_a, ex_b and ex_cin.

---
 rtl/int_add_rs.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/int_add_rs.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : int_add_rs                                                       |
// | Desc    : Integer add/sub reservation station with CDB snooping, feeding   |
// |           the carry-lookahead adder through a registered valid/ready port. |
// |           Optional subtract support: define INT_RS_SUB_EN.                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module int_add_rs #(
   parameter int ENTRIES = 4,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           issue_valid,
   output logic                           issue_ready,
   input  logic                           issue_op,
   input  logic [TAG_W-1:0]               issue_dest,
   input  logic [XLEN-1:0]                issue_vj,
   input  logic [XLEN-1:0]                issue_vk,
   input  logic [TAG_W-1:0]               issue_qj,
   input  logic [TAG_W-1:0]               issue_qk,
   input  logic                           issue_qj_busy,
   input  logic                           issue_qk_busy,
   input  logic                           cdb_valid,
   input  logic [TAG_W-1:0]               cdb_tag,
   input  logic [XLEN-1:0]                cdb_value,
   output logic                           ex_valid,
   input  logic                           ex_ready,
   output logic [XLEN-1:0]                ex_a,
   output logic [XLEN-1:0]                ex_b,
   output logic                           ex_cin,
   output logic [TAG_W-1:0]               ex_dest,
   output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

   localparam int c_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int c_OCC_W = $clog2(ENTRIES+1);

   logic [ENTRIES-1:0] r_valid;
   logic [ENTRIES-1:0] r_qj_busy;
   logic [ENTRIES-1:0] r_qk_busy;
   logic [TAG_W-1:0]   r_dest [ENTRIES];
   logic [TAG_W-1:0]   r_qj   [ENTRIES];
   logic [TAG_W-1:0]   r_qk   [ENTRIES];
   logic [XLEN-1:0]    r_vj   [ENTRIES];
   logic [XLEN-1:0]    r_vk   [ENTRIES];
`ifdef INT_RS_SUB_EN
   logic [ENTRIES-1:0] r_op;
`else
   logic               w_unused_op;
   assign w_unused_op = issue_op;
`endif

   logic [ENTRIES-1:0] w_ready;
   logic [c_IDX_W-1:0] w_free_idx;
   logic [c_IDX_W-1:0] w_sel_idx;
   logic               w_any_ready;
   logic [c_OCC_W-1:0] w_occ;
   logic               w_issue;
   logic               w_load;
   logic               w_dispatch;
   logic               w_fwd_j;
   logic               w_fwd_k;

   assign w_ready = r_valid & ~r_qj_busy & ~r_qk_busy;

   // Descending scan so the last hit is the lowest index.
   always_comb begin
      w_free_idx  = '0;
      w_sel_idx   = '0;
      w_any_ready = 1'b0;
      w_occ       = '0;
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = c_IDX_W'(i);
         if (w_ready[i]) begin
            w_sel_idx   = c_IDX_W'(i);
            w_any_ready = 1'b1;
         end
      end
      for (int i = 0; i < ENTRIES; i++) begin
         w_occ = w_occ + c_OCC_W'(r_valid[i]);
      end
   end

   assign occupancy   = w_occ;
   assign issue_ready = (w_occ != c_OCC_W'(ENTRIES));
   assign w_issue     = issue_valid && issue_ready;
   assign w_load      = !ex_valid || ex_ready;
   assign w_dispatch  = w_load && w_any_ready;
   assign w_fwd_j     = issue_qj_busy && cdb_valid && (issue_qj == cdb_tag);
   assign w_fwd_k     = issue_qk_busy && cdb_valid && (issue_qk == cdb_tag);

   // Free slot comes from registered valid bits, so a slot vacated by
   // dispatch this cycle cannot be refilled until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_qj_busy <= '0;
         r_qk_busy <= '0;
`ifdef INT_RS_SUB_EN
         r_op      <= '0;
`endif
         for (int i = 0; i < ENTRIES; i++) begin
            r_dest[i] <= '0;
            r_qj[i]   <= '0;
            r_qk[i]   <= '0;
            r_vj[i]   <= '0;
            r_vk[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_dispatch && (w_sel_idx == c_IDX_W'(i))) begin
               r_valid[i] <= 1'b0;
            end else if (w_issue && (w_free_idx == c_IDX_W'(i))) begin
               r_valid[i]   <= 1'b1;
`ifdef INT_RS_SUB_EN
               r_op[i]      <= issue_op;
`endif
               r_dest[i]    <= issue_dest;
               r_qj[i]      <= issue_qj;
               r_qk[i]      <= issue_qk;
               r_vj[i]      <= w_fwd_j ? cdb_value : issue_vj;
               r_vk[i]      <= w_fwd_k ? cdb_value : issue_vk;
               r_qj_busy[i] <= issue_qj_busy && !w_fwd_j;
               r_qk_busy[i] <= issue_qk_busy && !w_fwd_k;
            end else if (r_valid[i] && cdb_valid) begin
               if (r_qj_busy[i] && (r_qj[i] == cdb_tag)) begin
                  r_vj[i]      <= cdb_value;
                  r_qj_busy[i] <= 1'b0;
               end
               if (r_qk_busy[i] && (r_qk[i] == cdb_tag)) begin
                  r_vk[i]      <= cdb_value;
                  r_qk_busy[i] <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_cin   <= 1'b0;
         ex_dest  <= '0;
      end else if (w_load) begin
         ex_valid <= w_any_ready;
         if (w_any_ready) begin
            ex_a    <= r_vj[w_sel_idx];
            ex_dest <= r_dest[w_sel_idx];
`ifdef INT_RS_SUB_EN
            ex_b    <= r_op[w_sel_idx] ? ~r_vk[w_sel_idx] : r_vk[w_sel_idx];
            ex_cin  <= r_op[w_sel_idx];
`else
            ex_b    <= r_vk[w_sel_idx];
            ex_cin  <= 1'b0;
`endif
         end
      end
   end

endmodule
`default_nettype wire
